// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states and PC constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;
    localparam logic [31:0] INST_ZERO        = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_stage_chk.sv
// Protocol checks for the fetch stage and its instruction-memory port.
module if_fetch_stage_chk
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input fetch_state_t i_state,
    input logic         i_rvalid,
    input logic         i_redirect,
    input logic         i_req,
    input logic [1:0]   i_addr_lo
);

    // Read data may only return while a fetch is outstanding.
    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
        i_rvalid |-> (i_state == FS_WAIT));

    // Fetch addresses are always word aligned.
    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        i_req |-> (i_addr_lo == 2'b00));

    // No new request may be issued in a redirect cycle.
    a_no_req_on_redirect: assert property (@(posedge clk) disable iff (rst)
        i_redirect |-> !i_req);

endmodule

// File: rtl/if_pc_reg.sv
// Program counter register: loads a redirect target, otherwise steps by one word.
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    input  logic        i_adv,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_next
);

    logic [31:0] r_pc;

    // Sequential successor; 32-bit add wraps naturally past the top of memory.
    assign o_pc_next = r_pc + PC_STEP;
    assign o_pc      = r_pc;

    // PC update: a redirect load has priority over the sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= word_align(RESET_PC);
        end else if (i_load) begin
            r_pc <= word_align(i_load_pc);
        end else if (i_adv) begin
            r_pc <= o_pc_next;
        end else begin
            r_pc <= r_pc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch front end: single-outstanding fetch FSM feeding the IF/ID register.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc4,
    output logic [31:0]       out_inst,
    output logic              out_valid,
    output logic              flush_if_id
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_kill;
    logic         w_kill_nxt;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc4;
    logic [31:0]  w_addr;
    logic         w_req;
    logic         w_adv;
    logic         w_capture;
    logic [31:0]  r_out_pc;
    logic [31:0]  r_out_pc4;
    logic [31:0]  r_out_inst;
    logic         r_out_valid;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (redirect),
        .i_load_pc (redirect_pc),
        .i_adv     (w_adv),
        .o_pc      (w_pc),
        .o_pc_next (w_pc4)
    );

    // Next-state, request and kill logic; a redirect overrides every state and stall.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_req       = 1'b0;
        w_adv       = 1'b0;
        w_capture   = 1'b0;
        w_addr      = w_pc;
        if (redirect) begin
            // An in-flight fetch with no data yet must be killed when it lands.
            if ((r_state == FS_WAIT) && !imem_rvalid) begin
                w_state_nxt = FS_WAIT;
                w_kill_nxt  = 1'b1;
            end else begin
                w_state_nxt = FS_REQ;
                w_kill_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                FS_IDLE: begin
                    w_state_nxt = FS_REQ;
                end
                FS_REQ: begin
                    w_req = 1'b1;
                    if (imem_ready) begin
                        w_state_nxt = FS_WAIT;
                    end else begin
                        w_state_nxt = FS_REQ;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = FS_REQ;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = FS_HOLD;
                        end
                    end else begin
                        w_state_nxt = FS_WAIT;
                    end
                end
                FS_HOLD: begin
                    if (stall) begin
                        w_state_nxt = FS_HOLD;
                    end else begin
                        // Instruction consumed: fetch the next word in the same cycle.
                        w_req  = 1'b1;
                        w_adv  = 1'b1;
                        w_addr = w_pc4;
                        if (imem_ready) begin
                            w_state_nxt = FS_WAIT;
                        end else begin
                            w_state_nxt = FS_REQ;
                        end
                    end
                end
                default: begin
                    w_state_nxt = FS_IDLE;
                    w_kill_nxt  = 1'b0;
                end
            endcase
        end
    end

    // FSM state and kill flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FS_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    // IF/ID payload registers: cleared on redirect, loaded on accepted data, invalidated on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_pc    <= INST_ZERO;
            r_out_pc4   <= INST_ZERO;
            r_out_inst  <= INST_ZERO;
            r_out_valid <= 1'b0;
        end else if (redirect) begin
            r_out_pc    <= INST_ZERO;
            r_out_pc4   <= INST_ZERO;
            r_out_inst  <= INST_ZERO;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_pc    <= w_pc;
            r_out_pc4   <= w_pc4;
            r_out_inst  <= imem_rdata;
            r_out_valid <= 1'b1;
        end else if (w_adv) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign flush_if_id = redirect;
    assign out_pc      = r_out_pc;
    assign out_pc4     = r_out_pc4;
    assign out_inst    = r_out_inst;
    assign out_valid   = r_out_valid;

    if_fetch_stage_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_state    (r_state),
        .i_rvalid   (imem_rvalid),
        .i_redirect (redirect),
        .i_req      (w_req),
        .i_addr_lo  (w_addr[1:0])
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage with a variable-latency instruction memory model.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic        out_valid;
    logic        flush_if_id;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_out_q[$];

    int          mem_lat;
    int          mem_cnt;
    logic        mem_busy;
    logic [31:0] mem_paddr;
    logic        hs_s;
    logic [31:0] hs_addr;
    int          hs_lat;
    logic        prev_ov;
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .out_inst    (out_inst),
        .out_valid   (out_valid),
        .flush_if_id (flush_if_id)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_1234;
    endfunction

    // Memory model: handshake sampled mid-cycle, response driven just after the edge.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_busy    = 1'b0;
        mem_cnt     = 0;
        mem_paddr   = 32'h0;
        forever begin
            @(negedge clk);
            hs_s    = !rst && imem_req && imem_ready;
            hs_addr = imem_addr;
            hs_lat  = mem_lat;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rst) begin
                mem_busy = 1'b0;
            end else begin
                if (mem_busy) begin
                    if (mem_cnt == 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = inst_of(mem_paddr);
                        mem_busy    = 1'b0;
                    end else begin
                        mem_cnt = mem_cnt - 1;
                    end
                end
                if (hs_s) begin
                    if (hs_lat == 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = inst_of(hs_addr);
                    end else begin
                        mem_busy  = 1'b1;
                        mem_cnt   = hs_lat - 1;
                        mem_paddr = hs_addr;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every accepted request and every newly presented instruction.
    initial begin
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (imem_req && imem_ready) begin
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_addr: got unexpected request addr=%h expected none", imem_addr);
                    end else begin
                        mon_e = exp_addr_q.pop_front();
                        if (imem_addr !== mon_e) begin
                            bad++;
                            $display("FAIL sb_addr: got %h expected %h", imem_addr, mon_e);
                        end
                    end
                end
                if (out_valid && !prev_ov) begin
                    total++;
                    if (exp_out_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_out: got unexpected out_pc=%h expected none", out_pc);
                    end else begin
                        mon_e = exp_out_q.pop_front();
                        if (out_pc !== mon_e || out_pc4 !== mon_e + 32'd4 || out_inst !== inst_of(mon_e)) begin
                            bad++;
                            $display("FAIL sb_out: got pc=%h pc4=%h inst=%h expected pc=%h pc4=%h inst=%h",
                                     out_pc, out_pc4, out_inst, mon_e, mon_e + 32'd4, inst_of(mon_e));
                        end
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic wait_out(input logic [31:0] a, output logic found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_pc === a) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b expected 0", flush_if_id); end
        total++; if ({out_pc, out_pc4, out_inst} !== 96'h0) begin bad++; $display("FAIL rst_data: got %h %h %h expected 0", out_pc, out_pc4, out_inst); end
    endtask

    task automatic test_stream();
        logic [7:0] ov_pat;
        logic [7:0] rq_pat;
        ov_pat = 8'b1010_1000;
        rq_pat = 8'b0010_1010;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_out_q.push_back(32'h0);  exp_out_q.push_back(32'h4);  exp_out_q.push_back(32'h8);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) stall = 1'b1;
            @(negedge clk);
            total++; if (out_valid !== ov_pat[i]) begin bad++; $display("FAIL stream_valid c%0d: got %b expected %b", i + 1, out_valid, ov_pat[i]); end
            total++; if (imem_req !== rq_pat[i]) begin bad++; $display("FAIL stream_req c%0d: got %b expected %b", i + 1, imem_req, rq_pat[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== inst_of(32'h8) || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got v=%b pc=%h inst=%h req=%b expected v=1 pc=8 inst=%h req=0",
                         out_valid, out_pc, out_inst, imem_req, inst_of(32'h8));
            end
            @(posedge clk); #1;
        end
        exp_addr_q.push_back(32'hC);
        exp_out_q.push_back(32'hC);
        stall = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL stall_release: got req=%b addr=%h expected req=1 addr=c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        logic found;
        @(posedge clk); #1;
        mem_lat = 3;
        exp_addr_q.push_back(32'h10); exp_addr_q.push_back(32'h1000);
        exp_out_q.push_back(32'h1000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_ready === 1'b1 && imem_addr === 32'h10) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rdw_req10: got timeout expected request 10"); end
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h0000_1002;
        @(negedge clk);
        total++; if (flush_if_id !== 1'b1) begin bad++; $display("FAIL rdw_flush: got %b expected 1", flush_if_id); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        redirect = 1'b0; stall = 1'b1; mem_lat = 1;
        wait_out(32'h1000, found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rdw_out: got pc=%h timeout expected pc=1000", out_pc); end
        total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL rdw_flush_low: got %b expected 0", flush_if_id); end
    endtask

    task automatic test_redirect_rvalid();
        logic found;
        @(posedge clk); #1;
        exp_addr_q.push_back(32'h1004);
        stall = 1'b0;
        @(posedge clk); #1;
        exp_addr_q.push_back(32'h2000);
        exp_out_q.push_back(32'h2000);
        redirect = 1'b1; redirect_pc = 32'h0000_2000; stall = 1'b1;
        @(negedge clk);
        total++; if (flush_if_id !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rrv_flush: got flush=%b req=%b expected 1 0", flush_if_id, imem_req); end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rrv_dropped: got valid=%b expected 0", out_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin bad++; $display("FAIL rrv_refetch: got req=%b addr=%h expected 1 2000", imem_req, imem_addr); end
        wait_out(32'h2000, found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rrv_out: got timeout expected pc=2000"); end
        // Redirect from HOLD while stalled: redirect must win.
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_out_q.push_back(32'hFFFF_FFFC);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        total++; if (flush_if_id !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rst_beats_stall_flush: got flush=%b req=%b expected 1 0", flush_if_id, imem_req); end
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL redir_beats_stall: got v=%b pc=%h expected v=0 pc=0", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        logic found;
        wait_out(32'hFFFF_FFFC, found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL wrap_out: got timeout expected pc=fffffffc"); end
        total++; if (out_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h expected 00000000", out_pc4); end
        exp_addr_q.push_back(32'h0);
        exp_out_q.push_back(32'h0);
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 0", imem_req, imem_addr); end
        @(posedge clk); #1;
        stall = 1'b1;
        wait_out(32'h0, found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL wrap_out0: got timeout expected pc=0"); end
    endtask

    task automatic test_ready_low_and_reset();
        logic found;
        exp_addr_q.push_back(32'h4);
        @(posedge clk); #1;
        imem_ready = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL rdy_hold c%0d: got req=%b addr=%h expected 1 4", i, imem_req, imem_addr); end
            @(posedge clk); #1;
        end
        imem_ready = 1'b1; mem_lat = 3; stall = 1'b1;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || flush_if_id !== 1'b0) begin bad++; $display("FAIL arst_ctrl: got v=%b req=%b flush=%b expected 0 0 0", out_valid, imem_req, flush_if_id); end
        total++; if ({out_pc, out_pc4, out_inst} !== 96'h0) begin bad++; $display("FAIL arst_data: got %h %h %h expected 0", out_pc, out_pc4, out_inst); end
        exp_addr_q.push_back(32'h0);
        exp_out_q.push_back(32'h0);
        @(posedge clk); #1;
        mem_lat = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_idle: got req=%b expected 0", imem_req); end
        wait_out(32'h0, found);
        total++; if (found !== 1'b1 || out_inst !== inst_of(32'h0)) begin bad++; $display("FAIL arst_refetch: got found=%b inst=%h expected 1 %h", found, out_inst, inst_of(32'h0)); end
    endtask

    task automatic test_drain();
        repeat (3) @(negedge clk);
        total++; if (exp_addr_q.size() != 0) begin bad++; $display("FAIL drain_addr: got %0d pending expected 0", exp_addr_q.size()); end
        total++; if (exp_out_q.size() != 0) begin bad++; $display("FAIL drain_out: got %0d pending expected 0", exp_out_q.size()); end
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        mem_lat     = 1;
        repeat (2) @(posedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_ready_low_and_reset();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
